// File: rtl/mouse_tracker.sv
// Receive-only PS/2 mouse decoder: synchronises the PS/2 lines, deframes bytes,
// assembles 3-byte movement packets and keeps a clamped on-screen cursor position.
module mouse_tracker #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] mousex,
  output logic [9:0] mousey,
  output logic       mouseclick,
  output logic       packet_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} frame_state_t;

  // Clamp a signed coordinate into 0..hi.
  function automatic logic [9:0] clamp_coord(input logic signed [11:0] v,
                                             input logic signed [11:0] hi);
    if (v < 12'sd0)
      clamp_coord = 10'd0;
    else if (v > hi)
      clamp_coord = hi[9:0];
    else
      clamp_coord = v[9:0];
  endfunction

  // Sign-extend a 9-bit PS/2 delta, forcing it to zero on overflow.
  function automatic logic signed [11:0] delta_ext(input logic       sign,
                                                   input logic [7:0] low,
                                                   input logic       ovf);
    if (ovf)
      delta_ext = 12'sd0;
    else
      delta_ext = $signed({{3{sign}}, sign, low});
  endfunction

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_prev_q;
  logic             ps2_fall;
  logic             data_s;

  frame_state_t     state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             byte_ok, byte_err;
  logic [7:0]       rx_byte;

  logic [CNT_W-1:0] idle_cnt_q;
  logic             timeout_hit;

  logic [1:0]       pkt_idx_q, pkt_idx_d;
  logic [4:0]       flags_q, flags_d;   // {y_ovf, x_ovf, y_sign, x_sign, left}
  logic [7:0]       dx_low_q, dx_low_d;
  logic             apply;

  logic signed [11:0] dx, dy, sum_x, sum_y;
  logic [9:0]         next_x, next_y;

  // Synchroniser stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign ps2_fall    = clk_prev_q & ~clk_sync_q[1];
  assign data_s      = data_sync_q[1];
  assign rx_byte     = shift_q[7:0];
  // A falling edge in the same cycle as the timeout takes precedence.
  assign timeout_hit = (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !ps2_fall;

  // Frame deserialiser
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    byte_err  = 1'b0;
    if (ps2_fall) begin
      case (state_q)
        S_IDLE: begin
          if (!data_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
          end
        end
        S_DATA: begin
          shift_d   = {data_s, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8)
            state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (data_s && (^shift_q))
            byte_ok = 1'b1;
          else
            byte_err = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 9'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Idle watchdog: only runs while something is partially received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt_q <= '0;
    else if (ps2_fall || timeout_hit)
      idle_cnt_q <= '0;
    else if ((state_q != S_IDLE) || (pkt_idx_q != 2'd0))
      idle_cnt_q <= idle_cnt_q + CNT_W'(1);
  end

  // Packet assembler; index 0 requires bit3 of the flags byte for alignment.
  always_comb begin
    pkt_idx_d = pkt_idx_q;
    flags_d   = flags_q;
    dx_low_d  = dx_low_q;
    apply     = 1'b0;
    if (byte_err) begin
      pkt_idx_d = 2'd0;
    end else if (byte_ok) begin
      case (pkt_idx_q)
        2'd0: begin
          if (rx_byte[3]) begin
            flags_d   = {rx_byte[7:4], rx_byte[0]};
            pkt_idx_d = 2'd1;
          end
        end
        2'd1: begin
          dx_low_d  = rx_byte;
          pkt_idx_d = 2'd2;
        end
        default: begin
          apply     = 1'b1;
          pkt_idx_d = 2'd0;
        end
      endcase
    end else if (timeout_hit) begin
      pkt_idx_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_idx_q <= 2'd0;
      flags_q   <= 5'd0;
      dx_low_q  <= 8'd0;
    end else begin
      pkt_idx_q <= pkt_idx_d;
      flags_q   <= flags_d;
      dx_low_q  <= dx_low_d;
    end
  end

  // Position update; PS/2 +Y is up while screen rows grow downward.
  always_comb begin
    dx     = delta_ext(flags_q[1], dx_low_q, flags_q[3]);
    dy     = delta_ext(flags_q[2], rx_byte,  flags_q[4]);
    sum_x  = $signed({2'b00, mousex}) + dx;
    sum_y  = $signed({2'b00, mousey}) - dy;
    next_x = clamp_coord(sum_x, 12'(SCREEN_W - 1));
    next_y = clamp_coord(sum_y, 12'(SCREEN_H - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mousex       <= 10'(SCREEN_W / 2);
      mousey       <= 10'(SCREEN_H / 2);
      mouseclick   <= 1'b0;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= apply;
      if (apply) begin
        mousex     <= next_x;
        mousey     <= next_y;
        mouseclick <= flags_q[0];
      end
    end
  end

endmodule

// File: tb/tb_mouse_tracker.sv
// Bench for mouse_tracker: bit-level PS/2 driver, directed scenarios and a
// randomized run checked against an integer cursor model.
module tb_mouse_tracker;

  localparam int HALF    = 10;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] mousex, mousey;
  logic       mouseclick, packet_valid;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int mx = 320, my = 240, mc = 0;

  mouse_tracker #(.SCREEN_W(640), .SCREEN_H(480), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mousex(mousex), .mousey(mousey), .mouseclick(mouseclick),
    .packet_valid(packet_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (packet_valid === 1'b1) pulses++;

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    ps2_bit(1'b1);
  endtask

  // Expected cursor behaviour computed directly from the packet meaning.
  task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = mx + dx;
    if (mx < 0) mx = 0;
    if (mx > 639) mx = 639;
    my = my - dy;
    if (my < 0) my = 0;
    if (my > 479) my = 479;
    mc = int'(b0[0]);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    model_apply(b0, b1, b2);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mx = 320; my = 240; mc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mousex, mousey, mouseclick, packet_valid} !== {10'd320, 10'd240, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d c=%0d v=%0d want x=320 y=240 c=0 v=0",
               mousex, mousey, mouseclick, packet_valid);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int p0;
    do_reset();
    p0 = pulses;
    send_packet(8'h09, 8'h0A, 8'h00);
    checks++;
    if ({mousex, mousey, mouseclick} !== {10'd330, 10'd240, 1'b1}) begin
      errors++;
      $display("FAIL basic_pos: got x=%0d y=%0d c=%0d want x=330 y=240 c=1", mousex, mousey, mouseclick);
    end
    checks++;
    if (pulses - p0 !== 1) begin
      errors++;
      $display("FAIL basic_pulse: got %0d pulse cycles want 1", pulses - p0);
    end
  endtask

  task automatic test_y_and_release();
    do_reset();
    send_packet(8'h28, 8'h00, 8'hF6);
    checks++;
    if ({mousex, mousey} !== {10'd320, 10'd250}) begin
      errors++;
      $display("FAIL neg_dy: got x=%0d y=%0d want x=320 y=250", mousex, mousey);
    end
    send_packet(8'h08, 8'h05, 8'h00);
    checks++;
    if ({mousex, mousey, mouseclick} !== {10'd325, 10'd250, 1'b0}) begin
      errors++;
      $display("FAIL release: got x=%0d y=%0d c=%0d want x=325 y=250 c=0", mousex, mousey, mouseclick);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    send_packet(8'h08, 8'hFF, 8'hEB);
    send_packet(8'h08, 8'h3C, 8'h00);
    checks++;
    if ({mousex, mousey} !== {10'd635, 10'd5}) begin
      errors++;
      $display("FAIL clamp_setup: got x=%0d y=%0d want x=635 y=5", mousex, mousey);
    end
    send_packet(8'h08, 8'h64, 8'h64);
    checks++;
    if ({mousex, mousey} !== {10'd639, 10'd0}) begin
      errors++;
      $display("FAIL clamp_max: got x=%0d y=%0d want x=639 y=0", mousex, mousey);
    end
    send_packet(8'h18, 8'h9C, 8'h00);
    checks++;
    if ({mousex, mousey} !== {10'd539, 10'd0}) begin
      errors++;
      $display("FAIL neg_dx: got x=%0d y=%0d want x=539 y=0", mousex, mousey);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_packet(8'h48, 8'h50, 8'h03);
    checks++;
    if ({mousex, mousey} !== {10'd320, 10'd237}) begin
      errors++;
      $display("FAIL x_overflow: got x=%0d y=%0d want x=320 y=237", mousex, mousey);
    end
  endtask

  task automatic test_parity_error();
    int p0;
    do_reset();
    p0 = pulses;
    send_byte(8'h08, 1'b0);
    send_byte(8'h11, 1'b1);
    send_packet(8'h08, 8'h02, 8'h00);
    checks++;
    if ({mousex, mousey, pulses - p0} !== {10'd322, 10'd240, 32'd1}) begin
      errors++;
      $display("FAIL parity_drop: got x=%0d y=%0d pulses=%0d want x=322 y=240 pulses=1",
               mousex, mousey, pulses - p0);
    end
  endtask

  task automatic test_timeout();
    int p0;
    do_reset();
    p0 = pulses;
    send_byte(8'h09, 1'b0);
    send_byte(8'h50, 1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    checks++;
    if ({mousex, mousey, mouseclick, pulses - p0} !== {10'd320, 10'd240, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL timeout_hold: got x=%0d y=%0d c=%0d pulses=%0d want 320 240 0 0",
               mousex, mousey, mouseclick, pulses - p0);
    end
    send_packet(8'h08, 8'h07, 8'h00);
    checks++;
    if ({mousex, mousey, mouseclick, pulses - p0} !== {10'd327, 10'd240, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL timeout_resync: got x=%0d y=%0d c=%0d pulses=%0d want 327 240 0 1",
               mousex, mousey, mouseclick, pulses - p0);
    end
  endtask

  task automatic test_stray_byte();
    do_reset();
    send_byte(8'h00, 1'b0);
    send_packet(8'h09, 8'h03, 8'h04);
    checks++;
    if ({mousex, mousey, mouseclick} !== {10'd323, 10'd236, 1'b1}) begin
      errors++;
      $display("FAIL stray_byte: got x=%0d y=%0d c=%0d want x=323 y=236 c=1", mousex, mousey, mouseclick);
    end
  endtask

  task automatic test_reset_mid_packet();
    int p0;
    do_reset();
    send_packet(8'h09, 8'h20, 8'h00);
    p0 = pulses;
    send_byte(8'h09, 1'b0);
    send_byte(8'h10, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mousex, mousey, mouseclick, packet_valid} !== {10'd320, 10'd240, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got x=%0d y=%0d c=%0d v=%0d want 320 240 0 0",
               mousex, mousey, mouseclick, packet_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    send_packet(8'h09, 8'h01, 8'h01);
    checks++;
    if ({mousex, mousey, mouseclick, pulses - p0} !== {10'd321, 10'd239, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL after_reset: got x=%0d y=%0d c=%0d pulses=%0d want 321 239 1 1",
               mousex, mousey, mouseclick, pulses - p0);
    end
  endtask

  task automatic test_random();
    logic [7:0] b0, b1, b2;
    int p0;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      b0 = 8'($urandom);
      b0[3] = 1'b1;
      if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      p0 = pulses;
      send_packet(b0, b1, b2);
      checks++;
      if ({mousex, mousey, mouseclick, pulses - p0} !== {10'(mx), 10'(my), 1'(mc), 32'd1}) begin
        errors++;
        $display("FAIL random_%0d: pkt=%h %h %h got x=%0d y=%0d c=%0d pulses=%0d want x=%0d y=%0d c=%0d pulses=1",
                 n, b0, b1, b2, mousex, mousey, mouseclick, pulses - p0, mx, my, mc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1;
    int p0;
    do_reset();
    p0 = pulses;
    for (int n = 0; n < 3; n++) begin
      b1 = 8'($urandom);
      send_byte(8'h19, 1'b0);
      send_byte(b1, 1'b0);
      send_byte(8'h05, 1'b0);
      model_apply(8'h19, b1, 8'h05);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({mousex, mousey, mouseclick, pulses - p0} !== {10'(mx), 10'(my), 1'(mc), 32'd3}) begin
      errors++;
      $display("FAIL back_to_back: got x=%0d y=%0d c=%0d pulses=%0d want x=%0d y=%0d c=%0d pulses=3",
               mousex, mousey, mouseclick, pulses - p0, mx, my, mc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_y_and_release();
    test_clamp();
    test_overflow();
    test_parity_error();
    test_timeout();
    test_stray_byte();
    test_reset_mid_packet();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mouse_tracker.md
MOUSE_TRACKER -- requirements
Module: mouse_tracker

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning): SCREEN_W, 640, horizontal pixel count.
REQ-002 SCREEN_H, 480, vertical pixel count.
REQ-003 TIMEOUT_CYCLES, 5000, number of idle clk cycles inside a frame or packet that aborts it.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning): clk, in, 1, system clock, all logic on rising edge.
REQ-005 rst_n, in, 1, reset, asynchronous, active-low.
REQ-006 ps2_clk, in, 1, raw PS/2 clock line from the mouse, asynchronous to clk.
REQ-007 ps2_data, in, 1, raw PS/2 data line from the mouse, asynchronous to clk.
REQ-008 mousex, out, 10, cursor column in the range 0..SCREEN_W-1.
REQ-009 mousey, out, 10, cursor row in the range 0..SCREEN_H-1, with 0 at the top.
REQ-010 mouseclick, out, 1, left-button state from the last accepted packet.
REQ-011 packet_valid, out, 1, one-cycle pulse when a packet has been applied.

Function
REQ-012 The block SHALL be receive-only: it SHALL never drive ps2_clk or ps2_data, and mouse initialisation is out of scope.
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; a falling edge is sync[1]=0 with a previous sample of 1.
REQ-014 A frame SHALL be 11 bits sampled on successive falling edges: start bit 0, eight data bits LSB first, odd parity, stop bit 1.
REQ-015 Frame states SHALL be IDLE, then DATA (bits 1-9), then STOP.
REQ-016 In IDLE, a sampled start bit of 1 SHALL be ignored and the state SHALL stay IDLE.
REQ-017 A byte SHALL be accepted only when parity is odd over data plus parity and the stop bit is 1.
REQ-018 On a parity or stop error the byte SHALL be discarded and the packet byte index SHALL reset to 0.
REQ-019 A packet SHALL be 3 accepted bytes: B0 = flags, B1 = X delta low 8 bits, B2 = Y delta low 8 bits.
REQ-020 B0 bit0 SHALL be the left button, bit4 the X sign, bit5 the Y sign, bit6 X overflow and bit7 Y overflow.
REQ-021 A byte arriving at index 0 with bit3=0 SHALL be dropped and the index SHALL stay 0, so alignment resynchronises.
REQ-022 dx SHALL be the 9-bit two's-complement value {Xsign, B1} and dy SHALL be {Ysign, B2}.
REQ-023 If an axis overflow bit is set, that axis's delta SHALL be treated as 0; the button SHALL still be applied.
REQ-024 The new mousex SHALL be clamp(mousex + dx, 0, SCREEN_W-1), computed in signed arithmetic of at least 12 bits.
REQ-025 The new mousey SHALL be clamp(mousey - dy, 0, SCREEN_H-1), because PS/2 +Y is up and screen +Y is down.
REQ-026 mousex, mousey, mouseclick and packet_valid SHALL update together on the clk edge after the cycle in which the stop bit of B2 is sampled.
REQ-027 packet_valid SHALL be high for exactly that one cycle.
REQ-028 Between packets the outputs SHALL hold their values.
REQ-029 An idle counter SHALL clear on every falling edge of ps2_clk and increment while a frame is in progress or the packet index is nonzero.
REQ-030 When the idle counter reaches TIMEOUT_CYCLES, the frame state SHALL return to IDLE and the packet index SHALL return to 0, with no output change.
REQ-031 If a falling edge and a timeout occur in the same cycle, the edge SHALL win: the bit is sampled and the counter is cleared.
REQ-032 The block SHALL not assume any minimum gap between packets; B0 of the next packet may follow B2 immediately.

Reset
REQ-033 While rst_n=0, all state SHALL clear asynchronously: mousex=SCREEN_W/2 (320), mousey=SCREEN_H/2 (240), mouseclick=0, packet_valid=0, frame state IDLE, packet index 0, idle counter 0, synchronisers 1.
REQ-034 Reset asserted mid-frame or mid-packet SHALL discard the partial data; the first packet after release SHALL be decoded from a fresh B0.

Verification
REQ-035 A bench SHALL cover the following directed scenarios, each as stimulus -> required response:
- After reset, send packet 0x09, 0x0A, 0x00 -> mousex=330, mousey=240, mouseclick=1, one packet_valid pulse.
- From (320,240), send 0x28, 0x00, 0xF6 (dy=-10) -> mousey=250; then send 0x08, 0x05, 0x00 -> mouseclick=0, mousex=325.
- From (635,5), send 0x08, 0x64, 0x64 (dx=+100, dy=+100) -> mousex=639, mousey=0 (both clamped); a following 0x18, 0x9C, 0x00 (dx=-100) -> mousex=539.
- Send 0x48, 0x50, 0x03 (X overflow) -> mousex unchanged, mousey decreases by 3.
- Corrupt the parity of B1, then send a valid 3-byte packet -> only the valid packet is applied, exactly one packet_valid.
- Send B0 and B1, then idle for TIMEOUT_CYCLES+10 cycles, then send a full packet -> the partial packet is dropped and the full packet is applied correctly.
- Send a stray byte 0x00 at index 0 (bit3=0) before a valid packet -> 0x00 is ignored and the packet is decoded correctly.
- Assert rst_n mid-B2 -> outputs return to (320,240,0) immediately, with no packet_valid.
